// File: rtl/mem_ctrl_burst.sv
// mem_ctrl_burst: byte-serial burst RAM/IO controller arbitrating I-cache refills and LSB loads/stores.
// Define MC_RR_ARB_EN for round-robin arbitration; otherwise the LSB has fixed priority.
module mem_ctrl_burst #(
  parameter int ADDR_W = 32,
  parameter int IC_LINE_BYTES = 4,
  parameter int IO_SEL_HI = 17,
  parameter int IO_SEL_LO = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       clr_in,
  input  logic                       io_buffer_full,
  input  logic [7:0]                 mem_din,
  output logic [7:0]                 mem_dout,
  output logic [ADDR_W-1:0]          mem_a,
  output logic                       mem_wr,
  input  logic                       ic_req,
  input  logic [ADDR_W-1:0]          ic_addr,
  output logic                       ic_ready,
  output logic [IC_LINE_BYTES*8-1:0] ic_line,
  input  logic                       lsb_req,
  input  logic                       lsb_wr,
  input  logic [1:0]                 lsb_len,
  input  logic [ADDR_W-1:0]          lsb_addr,
  input  logic [31:0]                lsb_wdata,
  output logic                       lsb_ready,
  output logic [31:0]                lsb_rdata
);
  localparam int LW = IC_LINE_BYTES * 8;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic wr, wr_n, is_ic, is_ic_n, pick_ic, accept, stall, last, ic_rdy_n, lsb_rdy_n;
  logic [6:0] k, k_n, n, n_n;
  logic [LW-1:0] data, data_n, line_n;
  logic [31:0] rdata_n;
`ifdef MC_RR_ARB_EN
  logic last_ic;
  assign pick_ic = ic_req && (!lsb_req || !last_ic);
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) last_ic <= 1'b1;
    else if (rdy_in && accept) last_ic <= pick_ic;
`else
  assign pick_ic = ic_req && !lsb_req;
`endif
  assign accept = state == IDLE && !clr_in && (ic_req || lsb_req);
  // A store into the IO region bubbles while the IO write buffer is full
  assign stall = wr && (&mem_a[IO_SEL_HI:IO_SEL_LO]) && io_buffer_full;
  assign last = k == n - 7'd1;
  assign mem_wr = wr && !stall;
  assign mem_dout = wr ? data[{k, 3'b000} +: 8] : 8'h00;
  always_comb begin
    state_n = state;
    addr_n = mem_a;
    wr_n = wr;
    k_n = k;
    n_n = n;
    is_ic_n = is_ic;
    data_n = data;
    line_n = ic_line;
    rdata_n = lsb_rdata;
    ic_rdy_n = 1'b0;
    lsb_rdy_n = 1'b0;
    case (state)
      IDLE: begin
        addr_n = '0;
        if (accept) begin
          state_n = (pick_ic || !lsb_wr) ? READ : WRITE;
          addr_n = pick_ic ? ic_addr : lsb_addr;
          wr_n = !pick_ic && lsb_wr;
          k_n = '0;
          n_n = pick_ic ? 7'(IC_LINE_BYTES) : lsb_len == 2'd0 ? 7'd1 : lsb_len == 2'd1 ? 7'd2 : 7'd4;
          is_ic_n = pick_ic;
          data_n = (!pick_ic && lsb_wr) ? LW'(lsb_wdata) : '0;
        end
      end
      READ: begin
        if (clr_in) begin
          state_n = IDLE;
          addr_n = '0;
        end else begin
          data_n[{k, 3'b000} +: 8] = mem_din;
          k_n = k + 7'd1;
          addr_n = mem_a + ADDR_W'(1);
          if (last) begin
            state_n = DONE;
            line_n = is_ic ? data_n : ic_line;
            rdata_n = is_ic ? lsb_rdata : data_n[31:0];
            ic_rdy_n = is_ic;
            lsb_rdy_n = !is_ic;
          end
        end
      end
      WRITE: begin
        if (!stall) begin
          k_n = k + 7'd1;
          addr_n = last ? mem_a : mem_a + ADDR_W'(1);
          wr_n = !last;
          state_n = last ? DONE : WRITE;
          lsb_rdy_n = last;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      mem_a <= '0;
      wr <= 1'b0;
      k <= '0;
      n <= '0;
      is_ic <= 1'b0;
      data <= '0;
      ic_line <= '0;
      lsb_rdata <= '0;
      ic_ready <= 1'b0;
      lsb_ready <= 1'b0;
    end else if (rdy_in) begin
      state <= state_n;
      mem_a <= addr_n;
      wr <= wr_n;
      k <= k_n;
      n <= n_n;
      is_ic <= is_ic_n;
      data <= data_n;
      ic_line <= line_n;
      lsb_rdata <= rdata_n;
      ic_ready <= ic_rdy_n;
      lsb_ready <= lsb_rdy_n;
    end
endmodule

// File: tb/tb_mem_ctrl_burst.sv
// tb_mem_ctrl_burst: directed bench for mem_ctrl_burst with a combinational byte RAM and a write log.
module tb_mem_ctrl_burst;
  logic clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, clr_in = 1'b0, io_buffer_full = 1'b0;
  logic [7:0] mem_din, mem_dout;
  logic [31:0] mem_a;
  logic mem_wr;
  logic ic_req = 1'b0, ic_ready;
  logic [31:0] ic_addr = '0, ic_line;
  logic lsb_req = 1'b0, lsb_wr = 1'b0, lsb_ready;
  logic [1:0] lsb_len = '0;
  logic [31:0] lsb_addr = '0, lsb_wdata = '0, lsb_rdata;
  logic [7:0] ram [256];
  logic [31:0] wa [64];
  logic [7:0] wd [64];
  int wn = 0;
  int n_chk = 0, n_fail = 0;

  mem_ctrl_burst dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_ready(ic_ready), .ic_line(ic_line), .lsb_req(lsb_req), .lsb_wr(lsb_wr),
    .lsb_len(lsb_len), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_ready(lsb_ready), .lsb_rdata(lsb_rdata)
  );

  always #5 clk_in = ~clk_in;
  assign mem_din = ram[mem_a[7:0]];

  always @(posedge clk_in)
    if (rdy_in && mem_wr) begin
      wa[wn[5:0]] <= mem_a;
      wd[wn[5:0]] <= mem_dout;
      wn <= wn + 1;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_ready(input logic want_ic, input int start, output int lat);
    lat = start;
    for (int i = 0; i < 40; i++) begin
      cyc();
      lat++;
      if (want_ic ? ic_ready : lsb_ready) return;
    end
    lat = -1;
  endtask

  initial begin
    int lat, base;
    logic seen;
    logic [7:0] exp_g [4];
    logic [7:0] got_g;
`ifdef MC_RR_ARB_EN
    exp_g[0] = "L"; exp_g[1] = "I"; exp_g[2] = "L"; exp_g[3] = "I";
`else
    exp_g[0] = "L"; exp_g[1] = "L"; exp_g[2] = "L"; exp_g[3] = "L";
`endif
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    cyc();
    cyc();
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_ic_ready", ic_ready, 0);
    chk("rst_lsb_ready", lsb_ready, 0);
    chk("rst_ic_line", ic_line, 0);
    chk("rst_lsb_rdata", lsb_rdata, 0);
    rst_n_in = 1'b1;
    cyc();
    // I-cache refill of 0x100
    ram[8'h00] = 8'h11; ram[8'h01] = 8'h22; ram[8'h02] = 8'h33; ram[8'h03] = 8'h44;
    ic_req = 1'b1; ic_addr = 32'h100;
    cyc();
    chk("ic_e0_addr", mem_a, 32'h100);
    chk("ic_e0_wr", mem_wr, 0);
    wait_ready(1'b1, 1, lat);
    ic_req = 1'b0;
    chk("ic_latency", lat, 5);
    chk("ic_line", ic_line, 32'h44332211);
    cyc();
    chk("ic_ready_pulse", ic_ready, 0);
    // byte load
    ram[8'h02] = 8'h80; ram[8'h03] = 8'h55;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h2;
    cyc();
    wait_ready(1'b0, 1, lat);
    lsb_req = 1'b0;
    chk("lb_latency", lat, 2);
    chk("lb_rdata", lsb_rdata, 32'h80);
    cyc();
    // word store
    base = wn;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd2; lsb_addr = 32'h10; lsb_wdata = 32'hDEADBEEF;
    cyc();
    chk("sw_e0_wr", mem_wr, 1);
    chk("sw_e0_addr", mem_a, 32'h10);
    chk("sw_e0_dout", mem_dout, 8'hEF);
    wait_ready(1'b0, 1, lat);
    lsb_req = 1'b0;
    chk("sw_latency", lat, 5);
    chk("sw_count", wn - base, 4);
    chk("sw_b0", {wa[base], wd[base]}, {32'h10, 8'hEF});
    chk("sw_b1", {wa[base + 1], wd[base + 1]}, {32'h11, 8'hBE});
    chk("sw_b2", {wa[base + 2], wd[base + 2]}, {32'h12, 8'hAD});
    chk("sw_b3", {wa[base + 3], wd[base + 3]}, {32'h13, 8'hDE});
    cyc();
    // IO store with a 3-cycle full buffer
    base = wn;
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd0; lsb_addr = 32'h30000; lsb_wdata = 32'hA5;
    cyc();
    chk("io_stall1", mem_wr, 0);
    cyc();
    chk("io_stall2", mem_wr, 0);
    cyc();
    chk("io_stall3", {mem_wr, mem_a}, {1'b0, 32'h30000});
    cyc();
    io_buffer_full = 1'b0;
    #1;
    chk("io_resume", {mem_wr, mem_dout}, {1'b1, 8'hA5});
    wait_ready(1'b0, 4, lat);
    lsb_req = 1'b0;
    chk("io_latency", lat, 5);
    chk("io_count", wn - base, 1);
    chk("io_write", {wa[base], wd[base]}, {32'h30000, 8'hA5});
    cyc();
    // flush during a refill aborts with no ready
    ic_req = 1'b1; ic_addr = 32'h100;
    cyc();
    cyc();
    cyc();
    chk("clr_rd_addr_b2", mem_a, 32'h102);
    clr_in = 1'b1;
    cyc();
    clr_in = 1'b0; ic_req = 1'b0;
    chk("clr_rd_idle", {mem_wr, mem_a, ic_ready}, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      seen |= ic_ready;
    end
    chk("clr_rd_no_ready", seen, 0);
    chk("clr_rd_line_held", ic_line, 32'h44332211);
    // flush during a store is ignored
    base = wn;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd3; lsb_addr = 32'h20; lsb_wdata = 32'h11223344;
    cyc();
    cyc();
    clr_in = 1'b1;
    wait_ready(1'b0, 2, lat);
    clr_in = 1'b0; lsb_req = 1'b0;
    chk("clr_sw_latency", lat, 5);
    chk("clr_sw_count", wn - base, 4);
    chk("clr_sw_last", {wa[base + 3], wd[base + 3]}, {32'h23, 8'h11});
    cyc();
    // rdy_in freeze mid-store
    base = wn;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd1; lsb_addr = 32'h50; lsb_wdata = 32'hBEEF;
    cyc();
    cyc();
    rdy_in = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("frz_hold", {mem_a, mem_dout, lsb_ready}, {32'h51, 8'hBE, 1'b0});
    rdy_in = 1'b1;
    wait_ready(1'b0, 0, lat);
    lsb_req = 1'b0;
    chk("frz_latency", lat, 1);
    chk("frz_count", wn - base, 2);
    chk("frz_b1", {wa[base + 1], wd[base + 1]}, {32'h51, 8'hBE});
    cyc();
    // arbitration from a fresh reset
    rst_n_in = 1'b0;
    cyc();
    rst_n_in = 1'b1;
    ram[8'h02] = 8'h80;
    ic_addr = 32'h100; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h2;
    ic_req = 1'b1; lsb_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      got_g = "T";
      for (int i = 0; i < 40; i++) begin
        cyc();
        if (ic_ready || lsb_ready) begin
          got_g = lsb_ready ? "L" : "I";
          break;
        end
      end
      chk($sformatf("arb_grant%0d", g), got_g, exp_g[g]);
      if (g == 3) begin
        ic_req = 1'b0; lsb_req = 1'b0;
      end else begin
        if (got_g == "L") lsb_req = 1'b0; else ic_req = 1'b0;
        cyc();
        ic_req = 1'b1; lsb_req = 1'b1;
      end
    end
    cyc();
    // asynchronous reset mid-write, then a wrapping word load
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd2; lsb_addr = 32'h40; lsb_wdata = 32'h01020304;
    cyc();
    cyc();
    chk("arst_pre_wr", mem_wr, 1);
    rst_n_in = 1'b0;
    #1;
    chk("arst_wr", {mem_wr, mem_a, lsb_ready}, 0);
    lsb_req = 1'b0;
    cyc();
    rst_n_in = 1'b1;
    cyc();
    ram[8'hFE] = 8'h01; ram[8'hFF] = 8'h02; ram[8'h00] = 8'h03; ram[8'h01] = 8'h04;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd2; lsb_addr = 32'hFFFFFFFE;
    cyc();
    chk("wrap_a0", mem_a, 32'hFFFFFFFE);
    cyc();
    chk("wrap_a1", mem_a, 32'hFFFFFFFF);
    cyc();
    chk("wrap_a2", mem_a, 32'h0);
    cyc();
    chk("wrap_a3", mem_a, 32'h1);
    cyc();
    lsb_req = 1'b0;
    chk("wrap_ready", lsb_ready, 1);
    chk("wrap_rdata", lsb_rdata, 32'h04030201);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
